// File: rtl/mux2_pkg.sv
// Shared types for the round-robin 2:1 source selector.
// src_t names a source and is used for the select, the priority pointer and the grant.
package mux2_pkg;
    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;
    localparam int MUX2_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/mux2.sv
// Team 2:1 multiplexer cell: s_i=0 selects a_i, s_i=1 selects b_i.
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = s_i ? b_i : a_i;
endmodule

// File: rtl/mux2_rr_grant.sv
// Round-robin grant between two sources; the priority pointer moves only on advance_i.
module mux2_rr_grant
    import mux2_pkg::*;
(
    input  logic clk,
    input  logic n_reset,
    input  logic a_valid_i,
    input  logic b_valid_i,
    input  logic advance_i,
    output src_t grant_o,
    output logic any_o
);
    src_t prio_q, prio_d;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        any_o   = a_valid_i || b_valid_i;
        grant_o = SRC_A;
        if (a_valid_i && b_valid_i) begin
            grant_o = prio_q;
        end else if (b_valid_i) begin
            grant_o = SRC_B;
        end
    end

    // The source just served loses priority for the next contested cycle.
    always_comb begin
        prio_d = prio_q;
        if (advance_i) begin
            prio_d = (grant_o == SRC_A) ? SRC_B : SRC_A;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            prio_q <= SRC_A;
        end else begin
            prio_q <= prio_d;
        end
    end
endmodule

// File: rtl/mux2_rr_source_select.sv
// Arbitrates two valid/ready sources round-robin into one registered output stage,
// driving the registered mux select and saturating per-source grant counters.
module mux2_rr_source_select
    import mux2_pkg::*;
#(
    parameter int WIDTH = MUX2_DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    src_t             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic             load;
    logic             any;
    src_t             grant;
    logic [WIDTH-1:0] grant_data;

    assign load = !out_valid_q || out_ready;

    mux2_rr_grant u_grant (
        .clk      (clk),
        .n_reset  (n_reset),
        .a_valid_i(a_valid),
        .b_valid_i(b_valid),
        .advance_i(load && any),
        .grant_o  (grant),
        .any_o    (any)
    );

    // Only the granted source's data is passed, so X on the other source never loads.
    mux2 #(.WIDTH(WIDTH)) u_data_mux (
        .a_i(a_data),
        .b_i(b_data),
        .s_i(grant),
        .y_o(grant_data)
    );

    assign a_ready = load && any && (grant == SRC_A);
    assign b_ready = load && any && (grant == SRC_B);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sel_d       = sel_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        if (load) begin
            if (any) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                sel_d       = grant;
                if (grant == SRC_A && cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_W'(1);
                if (grant == SRC_B && cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sel_q       <= SRC_A;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sel_q       <= sel_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;
endmodule
